// File: rtl/ps2_transmit.sv
// ps2_transmit -- serialises two 10-button controller vectors onto a 5-bit bus.
// Each frame holds {controller, button code} for HOLD_CYCLES, then code 0 for
// GAP_CYCLES, then the other controller is examined (round-robin controllers).
// Optional build macro PS2_TX_ROUNDROBIN_EN: each controller remembers the last
// button it sent and the next search starts just after it, so simultaneously
// held buttons take turns. Without the macro the lowest set bit always wins.
module ps2_transmit #(
   parameter int HOLD_CYCLES = 600000,
   parameter int GAP_CYCLES  = 1000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [9:0] c1,
   input  logic [9:0] c2,
   output logic [4:0] GPIO_0,
   output logic       busy,
   output logic       frame_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [20:0] HOLD_LAST = 21'(HOLD_CYCLES - 1);
   localparam logic [20:0] GAP_LAST  = 21'(GAP_CYCLES - 1);

   state_t      state_q, state_d;
   logic        slot_q, slot_d;
   logic [20:0] cnt_q, cnt_d;
   logic [4:0]  gpio_q, gpio_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [9:0]  sel_vec_s;
   logic [3:0]  pick_idx_s;

`ifdef PS2_TX_ROUNDROBIN_EN
   logic [3:0]  last0_q, last0_d;
   logic [3:0]  last1_q, last1_d;
   logic [3:0]  last_sel_s;

   // Search starts after the previously sent index and wraps 9 -> 0.
   function automatic logic [3:0] pick_rr(input logic [9:0] vec, input logic [3:0] last);
      logic [3:0] idx;
      logic [3:0] cand;
      logic       found;
      idx   = 4'd0;
      found = 1'b0;
      cand  = (last >= 4'd9) ? 4'd0 : last + 4'd1;
      for (int k = 0; k < 10; k++) begin
         if (!found && vec[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
         cand = (cand == 4'd9) ? 4'd0 : cand + 4'd1;
      end
      return idx;
   endfunction
`else
   // Fixed priority: lowest set bit index wins.
   function automatic logic [3:0] pick_lowest(input logic [9:0] vec);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 9; i >= 0; i--) begin
         if (vec[i]) begin
            idx = 4'(i);
         end
      end
      return idx;
   endfunction
`endif

   assign sel_vec_s = slot_q ? c2 : c1;

`ifdef PS2_TX_ROUNDROBIN_EN
   assign last_sel_s = slot_q ? last1_q : last0_q;
   assign pick_idx_s = pick_rr(sel_vec_s, last_sel_s);
`else
   assign pick_idx_s = pick_lowest(sel_vec_s);
`endif

   // Next-state, counter and bus value for the IDLE/SEND/GAP sequencer.
   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      cnt_d   = cnt_q;
      gpio_d  = gpio_q;
`ifdef PS2_TX_ROUNDROBIN_EN
      last0_d = last0_q;
      last1_d = last1_q;
`endif
      case (state_q)
         IDLE: begin
            if (sel_vec_s == 10'd0) begin
               gpio_d = {slot_q, 4'd0};
               slot_d = ~slot_q;
            end else begin
               gpio_d  = {slot_q, pick_idx_s + 4'd1};
               state_d = SEND;
               cnt_d   = 21'd0;
`ifdef PS2_TX_ROUNDROBIN_EN
               if (slot_q) begin
                  last1_d = pick_idx_s;
               end else begin
                  last0_d = pick_idx_s;
               end
`endif
            end
         end
         SEND: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = GAP;
               cnt_d   = 21'd0;
               gpio_d  = {slot_q, 4'd0};
            end else begin
               cnt_d = cnt_q + 21'd1;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = IDLE;
               slot_d  = ~slot_q;
               cnt_d   = 21'd0;
            end else begin
               cnt_d = cnt_q + 21'd1;
            end
         end
         default: begin
            state_d = IDLE;
            slot_d  = 1'b0;
            cnt_d   = 21'd0;
            gpio_d  = 5'd0;
         end
      endcase
      // Status flags are registered from the next state so they line up with GPIO_0.
      busy_d = (state_d != IDLE);
      done_d = (state_d == GAP) && (cnt_d == GAP_LAST);
   end

   // State, counter and registered outputs; reset aborts any frame in flight.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         slot_q  <= 1'b0;
         cnt_q   <= 21'd0;
         gpio_q  <= 5'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         cnt_q   <= cnt_d;
         gpio_q  <= gpio_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

`ifdef PS2_TX_ROUNDROBIN_EN
   // Last-sent button index per controller; 9 makes the first search start at bit 0.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last0_q <= 4'd9;
         last1_q <= 4'd9;
      end else begin
         last0_q <= last0_d;
         last1_q <= last1_d;
      end
   end
`endif

   assign GPIO_0     = gpio_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule
